// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer.
//   seq_state_t  : sequencer FSM states
//   song_entry_t : one stored song entry {note, duration}
//   NOTE_REST    : note value meaning silence
//   END_MARK     : duration value that terminates a song
package song_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [2:0]  note;
        logic [15:0] duration;
    } song_entry_t;

    localparam logic [2:0]  NOTE_REST = 3'd0;
    localparam logic [15:0] END_MARK  = 16'd0;

    // True when the entry terminates the song.
    function automatic logic is_end_mark(input song_entry_t entry);
        return entry.duration == END_MARK;
    endfunction

endpackage

// File: rtl/song_mem.sv
// Song storage: DEPTH entries of {note, duration}.
//   clk, rst    : clock, synchronous active-high clear of every entry
//   wr_en       : write wr_entry to wr_addr at the clock edge
//   wr_addr     : entry index to write
//   wr_entry    : entry data to write
//   rd_addr     : combinational read index
//   rd_entry    : entry at rd_addr (pre-write value in a write cycle)
//   head_entry  : entry 0, used to decide whether a loop restart is legal
module song_mem
    import song_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  song_entry_t       wr_entry,
    input  logic [ADDR_W-1:0] rd_addr,
    output song_entry_t       rd_entry,
    output song_entry_t       head_entry
);

    song_entry_t entries [DEPTH];

    // Each entry is its own register so the whole memory can be cleared in
    // one cycle and read combinationally.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            song_entry_t entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rd_entry   = entries[rd_addr];
    assign head_entry = entries[0];

endmodule

// File: rtl/song_sequencer.sv
// Steps the multi-note player through a stored song.
//   clk, rst                 : clock, synchronous active-high reset (also clears the song)
//   wr_en/wr_addr/wr_note/wr_duration : song write port, usable in any state
//   start                    : play from entry 0 (only honoured in IDLE)
//   stop                     : abort playback, pulses player_rst
//   loop                     : at end of song, restart from entry 0
//   play_done                : player idle indication
//   play_load/play_note/play_duration : player load strobe and data (data 0 when not loading)
//   player_rst               : one-cycle player reset on abort
//   busy                     : not IDLE
//   idx                      : current entry index
//   song_done                : one-cycle pulse on normal completion
module song_sequencer
    import song_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_note,
    input  logic [15:0]       wr_duration,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              play_done,
    output logic              play_load,
    output logic [2:0]        play_note,
    output logic [15:0]       play_duration,
    output logic              player_rst,
    output logic              busy,
    output logic [ADDR_W-1:0] idx,
    output logic              song_done
);

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic              first_play_reg, first_play_next;

    song_entry_t wr_entry;
    song_entry_t cur_entry;
    song_entry_t head_entry;

    logic load_fire;
    logic stop_fire;
    logic end_fire;
    logic end_to_idle;

    assign wr_entry = '{note: wr_note, duration: wr_duration};

    song_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_entry   (wr_entry),
        .rd_addr    (idx_reg),
        .rd_entry   (cur_entry),
        .head_entry (head_entry)
    );

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        first_play_next = 1'b0;
        load_fire       = 1'b0;
        stop_fire       = 1'b0;
        end_fire        = 1'b0;
        end_to_idle     = 1'b0;

        case (state_reg)
            IDLE: begin
                // stop wins over start; stop in IDLE otherwise does nothing
                if (start && !stop) begin
                    state_next = LOAD;
                    idx_next   = '0;
                end
            end
            LOAD: begin
                if (stop) begin
                    stop_fire = 1'b1;
                end else if (is_end_mark(cur_entry)) begin
                    end_fire = 1'b1;
                end else if (play_done) begin
                    load_fire       = 1'b1;
                    state_next      = PLAY;
                    first_play_next = 1'b1;
                end
            end
            PLAY: begin
                // The player only drops done the cycle after a load, so a
                // high done in the first PLAY cycle is stale and ignored.
                if (stop) begin
                    stop_fire = 1'b1;
                end else if (!first_play_reg && play_done) begin
                    if (idx_reg == ADDR_W'(DEPTH - 1)) begin
                        end_fire = 1'b1;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase

        if (stop_fire) begin
            state_next = IDLE;
            idx_next   = '0;
        end

        // A loop restart is only taken if entry 0 holds a real note;
        // otherwise the song would immediately end again one cycle later.
        if (end_fire) begin
            idx_next = '0;
            if (loop && !is_end_mark(head_entry)) begin
                state_next = LOAD;
            end else begin
                state_next  = IDLE;
                end_to_idle = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            first_play_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            first_play_reg <= first_play_next;
        end
    end

    // Outputs are forced low while rst is asserted.
    assign play_load     = !rst && load_fire;
    assign play_note     = play_load ? cur_entry.note : NOTE_REST;
    assign play_duration = play_load ? cur_entry.duration : END_MARK;
    assign player_rst    = !rst && stop_fire;
    assign song_done     = !rst && end_to_idle;
    assign busy          = !rst && (state_reg != IDLE);
    assign idx           = rst ? '0 : idx_reg;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Controller that sequences the multi-note player through a stored song of (note, duration) entries.
- Holds a small song memory that is written through a write port.
- On start, issues one play_load per entry, waits for play_done, then advances to the next entry. Supports looping and abort.
- Sits between the top-level/board control logic and the multi-note player. Drives the player's play_load, play_note and play_duration inputs, plus a reset that is ORed into the player's rst.

Parameters:
- DEPTH, 16, number of song entries (power of two, 2..256).
- ADDR_W, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  write one song entry this cycle
- wr_addr  in  ADDR_W  entry index to write
- wr_note  in  3  note to write (0 = rest, 1..7 = note select)
- wr_duration  in  16  duration in cycles to write (0 = end-of-song marker)
- start  in  1  begin playing from entry 0 (accepted only in IDLE)
- stop  in  1  abort playback
- loop  in  1  at end of song, restart from entry 0 (sampled at end of song)
- play_done  in  1  from player: high when no note is in progress
- play_load  out  1  to player: load play_note/play_duration this cycle
- play_note  out  3  to player
- play_duration  out  16  to player
- player_rst  out  1  to player: one-cycle reset pulse on stop
- busy  out  1  high in any state other than IDLE
- idx  out  ADDR_W  index of the current entry
- song_done  out  1  one-cycle pulse when playback ends normally

Behaviour:
- Reset: state=IDLE, idx=0, all memory entries cleared to {note 0, duration 0}. All outputs are 0 during and after reset.
- Memory writes:
  - A write takes effect at the clock edge; read is combinational from idx.
  - A write to the entry being read in the same cycle: the old value is used for that cycle.
  - Writes are allowed in any state.
- States: IDLE, LOAD, PLAY.
- IDLE:
  - start=1 and stop=0 -> LOAD, idx=0.
  - stop=1 in IDLE: no state change, player_rst not pulsed.
- LOAD, with entry E=mem[idx]:
  - If E.duration==0, end of song is reached.
  - Otherwise, if play_done=1: play_load=1, play_note=E.note, play_duration=E.duration, next state PLAY.
  - Otherwise, if play_done=0: play_load=0 and stay in LOAD.
- PLAY:
  - The player drops play_done the cycle after the load. The block waits for play_done=1.
  - On play_done=1: if idx==DEPTH-1, end of song is reached; else idx+1 and go to LOAD.
  - play_done is ignored in the first PLAY cycle (the player's done is still low by its contract; ignoring it guards against a stale high).
- End of song:
  - loop=1 and the song is non-empty (entry 0 has duration!=0): idx=0, go to LOAD.
  - Otherwise: go to IDLE, idx=0, song_done=1 for exactly one cycle (the transition cycle).
  - An empty song (entry 0 duration 0) started from IDLE returns to IDLE with song_done, regardless of loop.
- Latency and outputs:
  - start to first play_load: 1 cycle (start in cycle 0, play_load in cycle 1, provided play_done=1).
  - play_note and play_duration are 0 whenever play_load=0.
- stop:
  - stop=1 in LOAD or PLAY -> IDLE, idx=0, player_rst=1 for one cycle. No song_done.
  - stop has priority over start, play_done and end of song in the same cycle.
- A start while busy is ignored.
- rst mid-operation behaves exactly as reset and clears memory. player_rst is not driven by rst; the top level ORs rst into the player separately.
- idx wraps only through the end-of-song rules. No modular overflow is ever visible.

Decomposition:
- Package song_pkg:
  - seq_state_t enum {IDLE, LOAD, PLAY}.
  - song_entry_t packed struct {note[2:0], duration[15:0]}.
  - NOTE_REST = 3'd0 constant.
  - END_MARK = 16'd0 constant.
- Sub-module song_mem: a DEPTH x 19-bit register file with one synchronous write port, one combinational read port, and synchronous clear on rst.
- The FSM and idx counter live in song_sequencer.

Test Plan:
- Single entry: write {1, 2} at 0 and {0, 0} at 1. Drive start in cycle 0 with a player model.
  - Expected: play_load=1, note=1, dur=2 in cycle 1; busy=1; song_done pulses after the player's done returns; then IDLE with idx=0.
- Three-entry song: {2, 4}, {0, 3}, {7, 1}, end marker.
  - Expected: three play_loads in order with idx 0, 1, 2; each load occurs the cycle after play_done rises; a rest entry (note 0) is still loaded; then one song_done.
- Loop: same song with loop=1.
  - Expected: after entry 2 completes, play_load with idx=0, note=2 follows; no song_done. Dropping loop before the end yields song_done.
- Stop mid-note: stop in the 2nd PLAY cycle of {3, 6}.
  - Expected: player_rst=1 for one cycle, state IDLE, idx=0, no song_done. A subsequent start replays from entry 0.
- Edge cases:
  - An empty song plus start gives song_done the next cycle with no play_load.
  - A full DEPTH song with no marker ends after entry DEPTH-1.
  - start and stop together in IDLE: stays IDLE.
  - play_done held low in LOAD stalls with no play_load.
- Reset during PLAY: busy=0, idx=0, all memory reads return 0. A following start produces an immediate song_done.
